// File: rtl/fpu_signq.sv
// Issue-side sign tag queue: holds {Xs, Ys, Sqrt, Op} in issue order across multicycle
// units and, on each unit result, retires the oldest tag into a registered result sign.
module fpu_signq #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         FlushE,
    input  logic                         IssueValid,
    output logic                         IssueReady,
    input  logic                         IssueXs,
    input  logic                         IssueYs,
    input  logic                         IssueSqrt,
    input  logic [1:0]                   IssueOp,
    input  logic                         ResultValid,
    input  logic                         FmaSs,
    input  logic                         CvtCs,
    output logic                         Ms,
    output logic                         MsValid,
    output logic [$clog2(DEPTH+1)-1:0]   Count,
    output logic                         Underflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [1:0] OP_FMA = 2'b00;
    localparam logic [1:0] OP_DIV = 2'b01;
    localparam logic [1:0] OP_CVT = 2'b10;

    // Tag layout: [4] Xs, [3] Ys, [2] Sqrt, [1:0] Op
    logic [4:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ready;
    logic          r_ms;
    logic          r_ms_valid;
    logic          r_underflow;

    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [4:0]    w_wdata;
    logic [4:0]    w_head;
    logic          w_sel_sign;
    logic [CW-1:0] w_count_next;

    assign w_empty = (r_count == '0);
    // Ready is the registered not-full flag, so a same-cycle pop never frees a slot early.
    assign w_push  = IssueValid & r_ready & ~FlushE;
    assign w_pop   = ResultValid & ~w_empty & ~FlushE;
    assign w_wdata = {IssueXs, IssueYs, IssueSqrt, IssueOp};
    assign w_head  = r_mem[r_rptr];

    always_comb begin
        w_sel_sign = 1'b0;
        case (w_head[1:0])
            OP_FMA:  w_sel_sign = FmaSs;
            OP_DIV:  w_sel_sign = w_head[4] ^ (w_head[3] & ~w_head[2]);
            OP_CVT:  w_sel_sign = CvtCs;
            default: w_sel_sign = 1'b0;
        endcase
    end

    always_comb begin
        w_count_next = r_count;
        if (FlushE) begin
            w_count_next = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_next = r_count + 1'b1;
                2'b01:   w_count_next = r_count - 1'b1;
                default: w_count_next = r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wptr] <= w_wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_ready     <= 1'b1;
            r_ms        <= 1'b0;
            r_ms_valid  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count    <= w_count_next;
            r_ready    <= (w_count_next != CW'(DEPTH));
            r_ms_valid <= w_pop;
            if (FlushE) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + 1'b1;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + 1'b1;
                    r_ms   <= w_sel_sign;
                end
                // No bypass: a result arriving with nothing queued is an underflow even if a tag is pushed now.
                if (ResultValid && w_empty) begin
                    r_underflow <= 1'b1;
                end
            end
        end
    end

    assign IssueReady = r_ready;
    assign Ms         = r_ms;
    assign MsValid    = r_ms_valid;
    assign Count      = r_count;
    assign Underflow  = r_underflow;

endmodule

// File: tb/tb_fpu_signq.sv
// Directed bench for fpu_signq: each step drives inputs, clocks once, then checks outputs.
module tb_fpu_signq;

    logic       clk = 1'b0;
    logic       resetn;
    logic       FlushE;
    logic       IssueValid;
    logic       IssueReady;
    logic       IssueXs;
    logic       IssueYs;
    logic       IssueSqrt;
    logic [1:0] IssueOp;
    logic       ResultValid;
    logic       FmaSs;
    logic       CvtCs;
    logic       Ms;
    logic       MsValid;
    logic [2:0] Count;
    logic       Underflow;

    int checks = 0;
    int failures = 0;

    fpu_signq #(.DEPTH(4)) dut (
        .clk(clk), .resetn(resetn), .FlushE(FlushE),
        .IssueValid(IssueValid), .IssueReady(IssueReady),
        .IssueXs(IssueXs), .IssueYs(IssueYs), .IssueSqrt(IssueSqrt), .IssueOp(IssueOp),
        .ResultValid(ResultValid), .FmaSs(FmaSs), .CvtCs(CvtCs),
        .Ms(Ms), .MsValid(MsValid), .Count(Count), .Underflow(Underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        FlushE = 0; IssueValid = 0; ResultValid = 0;
        IssueXs = 0; IssueYs = 0; IssueSqrt = 0; IssueOp = 2'b00;
        FmaSs = 0; CvtCs = 0;
    endtask

    task automatic set_push(input logic xs, input logic ys, input logic sq, input logic [1:0] op);
        IssueValid = 1; IssueXs = xs; IssueYs = ys; IssueSqrt = sq; IssueOp = op;
    endtask

    task automatic chk_out(input string tag, input logic mv, input logic ms, input logic [2:0] cnt);
        chk({tag, "_msvalid"}, 32'(MsValid), 32'(mv));
        chk({tag, "_ms"}, 32'(Ms), 32'(ms));
        chk({tag, "_count"}, 32'(Count), 32'(cnt));
        $display("step %-10s mv=%0b ms=%0b cnt=%0d rdy=%0b uf=%0b", tag, MsValid, Ms, Count, IssueReady, Underflow);
    endtask

    initial begin
        idle_inputs();
        resetn = 0;
        #12;
        // 1. reset then idle
        chk("rst_ready", 32'(IssueReady), 1);
        chk("rst_uf", 32'(Underflow), 0);
        chk_out("rst", 0, 0, 0);
        resetn = 1;
        step();
        chk_out("idle", 0, 0, 0);
        chk("idle_ready", 32'(IssueReady), 1);

        // 2. DIV then SQRT
        set_push(1, 1, 0, 2'b01); step(); idle_inputs();
        chk_out("div_push", 0, 0, 1);
        ResultValid = 1; step(); idle_inputs();
        chk_out("div_pop", 1, 0, 0);
        step();
        chk_out("div_idle", 0, 0, 0);
        set_push(1, 1, 1, 2'b01); step(); idle_inputs();
        ResultValid = 1; step(); idle_inputs();
        chk_out("sqrt_pop", 1, 1, 0);

        // 3. FMA then CVT, FmaSs=1 CvtCs=0
        set_push(0, 0, 0, 2'b00); step(); idle_inputs();
        set_push(1, 1, 0, 2'b10); step(); idle_inputs();
        chk_out("fc_push", 0, 1, 2);
        ResultValid = 1; FmaSs = 1; CvtCs = 0; step();
        chk_out("fma_pop", 1, 1, 1);
        step(); idle_inputs();
        chk_out("cvt_pop", 1, 0, 0);

        // 4. fill, ignored 5th push, wrap; DIV ys=1 sqrt=1 gives Ms = Xs
        set_push(1, 1, 1, 2'b01); step();
        set_push(0, 1, 1, 2'b01); step();
        set_push(0, 1, 1, 2'b01); step();
        set_push(1, 1, 1, 2'b01); step(); idle_inputs();
        chk_out("fill", 0, 0, 4);
        chk("fill_ready", 32'(IssueReady), 0);
        set_push(0, 1, 1, 2'b01); step(); idle_inputs();
        chk_out("push5", 0, 0, 4);
        chk("push5_ready", 32'(IssueReady), 0);
        // pop while full with a push offered: push must be refused
        set_push(0, 1, 1, 2'b01); ResultValid = 1; step(); idle_inputs();
        chk_out("popfull", 1, 1, 3);
        // simultaneous push/pop at count 3
        set_push(1, 1, 1, 2'b01); ResultValid = 1; step(); idle_inputs();
        chk_out("pushpop", 1, 0, 3);
        ResultValid = 1; step();
        chk_out("drain1", 1, 0, 2);
        step();
        chk_out("drain2", 1, 1, 1);
        step(); idle_inputs();
        chk_out("drain3", 1, 1, 0);

        // 5. ResultValid on empty
        ResultValid = 1; step(); idle_inputs();
        chk_out("uf_empty", 0, 1, 0);
        chk("uf_set", 32'(Underflow), 1);
        set_push(1, 1, 0, 2'b01); ResultValid = 1; step(); idle_inputs();
        chk_out("uf_push", 0, 1, 1);
        ResultValid = 1; step(); idle_inputs();
        chk_out("uf_pop", 1, 0, 0);
        chk("uf_sticky", 32'(Underflow), 1);

        // 6. flush with count 3 and concurrent push/pop
        set_push(1, 1, 1, 2'b01); step();
        step();
        step(); idle_inputs();
        chk_out("pre_flush", 0, 0, 3);
        FlushE = 1; ResultValid = 1; set_push(1, 1, 1, 2'b01); step(); idle_inputs();
        chk_out("flush", 0, 0, 0);
        chk("flush_uf", 32'(Underflow), 1);
        chk("flush_ready", 32'(IssueReady), 1);
        ResultValid = 1; step(); idle_inputs();
        chk_out("post_flush", 0, 0, 0);

        // async reset mid-stream
        set_push(1, 1, 1, 2'b01); step();
        set_push(0, 1, 1, 2'b01); step(); idle_inputs();
        ResultValid = 1; step(); idle_inputs();
        chk_out("pre_rst", 1, 1, 1);
        #2;
        resetn = 0;
        #1;
        chk_out("async_rst", 0, 0, 0);
        chk("async_rst_uf", 32'(Underflow), 0);
        chk("async_rst_ready", 32'(IssueReady), 1);
        #5;
        resetn = 1;
        step();
        chk_out("after_rst", 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
